bram_port_initiator: RTL

- Initiator for one port of the dual-ported write-first BRAM primitive.
- Turns a valid/ready request stream (reads and writes) into the BRAM's EN/WE/ADDR/DI pins.
- Tracks the fixed BRAM read latency and buffers read data in a small response FIFO, so a stalled consumer never loses data.
- Sits between Bluespec-side logic (e.g. IOCap table lookup) and the BRAM instance; two instances drive ports A and B.

---
 rtl/bram_port_pkg.sv | 24 ++
 rtl/bram_resp_fifo.sv | 81 ++++++++
 rtl/bram_port_initiator.sv | 99 +++++++++
 3 files changed

// File: rtl/bram_port_pkg.sv
// Shared definitions for the BRAM port initiator and its response FIFO.
//   bram_read_latency : cycles from an accepted read to valid BRAM DO.
//   clog2             : ceiling log2 for sizing counters and pointers.
//   MIN_RESP_DEPTH    : smallest usable response FIFO depth.
package bram_port_pkg;

    localparam int MIN_RESP_DEPTH = 1;

    // An unpipelined BRAM registers address only (1 cycle); the pipelined
    // variant adds an output register (2 cycles).
    function automatic int bram_read_latency(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous FIFO with a registered head, holding BRAM read data until
// the consumer takes it.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : enqueue push_data this edge
//   push_data  : data to enqueue
//   pop        : dequeue the head this edge (ignored when empty)
//   head       : registered copy of the oldest entry, valid when count != 0
//   count      : number of stored entries
// Push and pop in the same cycle are both honoured, including when full.
// Pointers wrap at DEPTH, so non-power-of-two depths work.
module bram_resp_fifo
    import bram_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop     = pop && (count != '0);
    // A push into a full FIFO is only taken when the head leaves at the same edge.
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rd_ptr_inc = ptr_inc(rd_ptr);

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Head refresh: after a pop with older entries left the next one
            // is already in storage; otherwise the incoming word becomes head
            // when the FIFO is (or is about to be) empty.
            if (do_pop && (count > CNT_W'(1))) begin
                head <= mem[rd_ptr_inc];
            end else if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1))))) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/bram_port_initiator.sv
// Initiator for one port of a dual-ported write-first BRAM. Converts a
// valid/ready request stream into BRAM EN/WE/ADDR/DI and returns read data
// through a response FIFO sized so a stalled consumer never loses data.
//   CLK, RST        : clock (also the BRAM port clock), async active-high reset
//   REQ_*           : request stream (REQ_WE=1 write, 0 read)
//   RSP_*           : read response stream, in request order
//   BRAM_EN/WE/ADDR/DI : to the BRAM port; BRAM_DO from it
//   BUSY            : reads in flight or responses buffered
// Handshake: a transfer happens on a rising CLK edge where VALID and READY
// are both high; the producer holds VALID and its payload until then, and
// READY never depends combinationally on the same interface's VALID.
module bram_port_initiator
    import bram_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO,
    output logic                  BUSY
);

    localparam int LAT   = bram_read_latency(PIPELINED);
    localparam int RES_W = clog2(RESP_DEPTH + 1);

    if (RESP_DEPTH < MIN_RESP_DEPTH) begin : g_depth_check
        $error("bram_port_initiator: RESP_DEPTH must be at least %0d", MIN_RESP_DEPTH);
    end

    // reserved counts reads accepted but not yet dequeued (in flight plus
    // buffered), so every accepted read already owns a FIFO slot.
    logic [RES_W-1:0] reserved;
    logic [LAT-1:0]   pipe;
    logic [RES_W-1:0] fifo_count;
    logic             rd_fire;
    logic             rsp_fire;

    assign REQ_READY = !RST && (reserved < RES_W'(RESP_DEPTH));

    assign BRAM_EN   = REQ_VALID & REQ_READY;
    assign BRAM_WE   = REQ_WE & BRAM_EN;
    assign BRAM_ADDR = REQ_ADDR;
    assign BRAM_DI   = REQ_DATA;

    assign rd_fire   = BRAM_EN & ~REQ_WE;
    assign rsp_fire  = RSP_VALID & RSP_READY;

    assign RSP_VALID = (fifo_count != '0);
    assign BUSY      = (|pipe) | (fifo_count != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reserved <= '0;
        end else if (rd_fire && !rsp_fire) begin
            reserved <= reserved + RES_W'(1);
        end else if (!rd_fire && rsp_fire) begin
            reserved <= reserved - RES_W'(1);
        end
    end

    // pipe[i] marks a read issued i+1 edges ago; the truncating cast drops
    // the oldest bit, giving pipe[0] <= rd_fire, pipe[i] <= pipe[i-1].
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe <= '0;
        end else begin
            pipe <= LAT'({pipe, rd_fire});
        end
    end

    bram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (pipe[LAT-1]),
        .push_data (BRAM_DO),
        .pop       (rsp_fire),
        .head      (RSP_DATA),
        .count     (fifo_count)
    );

endmodule
